simd_core: RTL and testbench

- Four-lane, 8-bit unsigned SIMD ALU with 16-bit per-lane results.
- One opcode is broadcast to all lanes, which operate in parallel.
- Results are registered with a single-cycle latency, so the block sits as one pipeline stage in the mini-GPU datapath.

---
 rtl/simd_pkg.sv | 15 +
 rtl/simd_lane.sv | 29 ++
 rtl/simd_core.sv | 61 ++++++
 tb/tb_simd_core.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared widths, opcode encoding and opcode type for the four-lane SIMD ALU.
package simd_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int LANES  = 4;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'b00;
  localparam opcode_t OP_SUB = 2'b01;
  localparam opcode_t OP_MUL = 2'b10;
  localparam opcode_t OP_MAX = 2'b11;

endpackage

// File: rtl/simd_lane.sv
// One combinational ALU lane: unsigned 8-bit operands, 16-bit result.
module simd_lane
  import simd_pkg::*;
(
  input  opcode_t             opcode,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [RES_W-1:0]    res
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = RES_W'(a);
  assign b_ext = RES_W'(b);

  always_comb begin
    res = '0;
    case (opcode)
      OP_ADD:  res = a_ext + b_ext;
      // Wraps modulo 2^16, so a<b yields the two's-complement negative value.
      OP_SUB:  res = a_ext - b_ext;
      OP_MUL:  res = a_ext * b_ext;
      OP_MAX:  res = (a >= b) ? a_ext : b_ext;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/simd_core.sv
// Four-lane SIMD ALU stage: broadcast opcode, per-lane results registered with one-cycle latency.
module simd_core
  import simd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  opcode_t             opcode,
  input  logic [DATA_W-1:0]   a0,
  input  logic [DATA_W-1:0]   b0,
  input  logic [DATA_W-1:0]   a1,
  input  logic [DATA_W-1:0]   b1,
  input  logic [DATA_W-1:0]   a2,
  input  logic [DATA_W-1:0]   b2,
  input  logic [DATA_W-1:0]   a3,
  input  logic [DATA_W-1:0]   b3,
  output logic [RES_W-1:0]    r0,
  output logic [RES_W-1:0]    r1,
  output logic [RES_W-1:0]    r2,
  output logic [RES_W-1:0]    r3,
  output logic                out_valid
);

  logic [LANES-1:0][DATA_W-1:0] a_lane;
  logic [LANES-1:0][DATA_W-1:0] b_lane;
  logic [LANES-1:0][RES_W-1:0]  res_lane;
  logic [LANES-1:0][RES_W-1:0]  res_q;
  logic                         valid_q;

  assign a_lane = {a3, a2, a1, a0};
  assign b_lane = {b3, b2, b1, b0};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_lane u_lane (
      .opcode (opcode),
      .a      (a_lane[i]),
      .b      (b_lane[i]),
      .res    (res_lane[i])
    );
  end

  // Results hold across idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_lane;
      end
    end
  end

  assign r0        = res_q[0];
  assign r1        = res_q[1];
  assign r2        = res_q[2];
  assign r3        = res_q[3];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_simd_core.sv
// Self-checking bench for simd_core: directed literal cases plus randomized traffic against a behavioural model.
module tb_simd_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic [7:0]  a0 = 0, b0 = 0, a1 = 0, b1 = 0, a2 = 0, b2 = 0, a3 = 0, b3 = 0;
  logic [15:0] r0, r1, r2, r3;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what the outputs must show right now.
  logic [15:0] m_r [4];
  logic        m_v;

  simd_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_fn(input logic [1:0] op, input int a, input int b);
    int v;
    case (op)
      2'b00:   v = a + b;
      2'b01:   v = (a - b + 65536) % 65536;
      2'b10:   v = a * b;
      default: v = (a >= b) ? a : b;
    endcase
    return v[15:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the capture edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid) begin
        m_r[0] = ref_fn(opcode, a0, b0);
        m_r[1] = ref_fn(opcode, a1, b1);
        m_r[2] = ref_fn(opcode, a2, b2);
        m_r[3] = ref_fn(opcode, a3, b3);
        m_v = 1'b1;
      end else begin
        m_v = 1'b0;
      end
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
    m_v = 1'b0;
  end

  initial begin
    for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
    m_v = 1'b0;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_valid", {15'b0, out_valid}, {15'b0, m_v});
    chk("cmp_r0", r0, m_r[0]);
    chk("cmp_r1", r1, m_r[1]);
    chk("cmp_r2", r2, m_r[2]);
    chk("cmp_r3", r3, m_r[3]);
  end

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [7:0] xa0, input logic [7:0] xb0,
                       input logic [7:0] xa1, input logic [7:0] xb1,
                       input logic [7:0] xa2, input logic [7:0] xb2,
                       input logic [7:0] xa3, input logic [7:0] xb3);
    in_valid = v; opcode = op;
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    a2 = xa2; b2 = xb2; a3 = xa3; b3 = xb3;
  endtask

  task automatic expect4(input string name, input logic v,
                         input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
    chk({name, "_valid"}, {15'b0, out_valid}, {15'b0, v});
    chk({name, "_r0"}, r0, e0);
    chk({name, "_r1"}, r1, e1);
    chk({name, "_r2"}, r2, e2);
    chk({name, "_r3"}, r3, e3);
  endtask

  initial begin
    // Reset state
    #3;
    expect4("reset_init", 1'b0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // ADD basic
    @(negedge clk); drive(1, 2'b00, 5, 2, 10, 3, 7, 1, 8, 4);
    @(negedge clk); expect4("add", 1'b1, 7, 13, 8, 12);
    drive(1, 2'b10, 5, 2, 10, 3, 7, 1, 8, 4);
    @(negedge clk); expect4("mul", 1'b1, 10, 30, 7, 32);
    drive(1, 2'b10, 255, 255, 0, 9, 1, 1, 16, 16);
    @(negedge clk); expect4("mul_corner", 1'b1, 16'hFE01, 0, 1, 256);
    drive(1, 2'b01, 5, 2, 10, 3, 7, 1, 8, 4);
    @(negedge clk); expect4("sub", 1'b1, 3, 7, 6, 4);
    drive(1, 2'b01, 2, 5, 0, 255, 9, 9, 255, 0);
    @(negedge clk); expect4("sub_neg", 1'b1, 16'hFFFD, 16'hFF01, 0, 255);
    drive(1, 2'b11, 5, 2, 3, 10, 7, 7, 0, 255);
    @(negedge clk); expect4("max", 1'b1, 5, 10, 7, 255);
    drive(1, 2'b00, 255, 255, 255, 0, 0, 0, 128, 128);
    @(negedge clk); expect4("add_ovf", 1'b1, 510, 255, 0, 256);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); expect4("idle_hold", 1'b0, 510, 255, 0, 256);

    // Throughput: ADD, MUL, SUB back-to-back, then idle hold
    drive(1, 2'b00, 5, 2, 10, 3, 7, 1, 8, 4);
    @(negedge clk); expect4("b2b_add", 1'b1, 7, 13, 8, 12);
    drive(1, 2'b10, 5, 2, 10, 3, 7, 1, 8, 4);
    @(negedge clk); expect4("b2b_mul", 1'b1, 10, 30, 7, 32);
    drive(1, 2'b01, 5, 2, 10, 3, 7, 1, 8, 4);
    @(negedge clk); expect4("b2b_sub", 1'b1, 3, 7, 6, 4);
    drive(0, 2'b11, 99, 1, 99, 1, 99, 1, 99, 1);
    @(negedge clk); expect4("b2b_hold", 1'b0, 3, 7, 6, 4);
    @(negedge clk); expect4("b2b_hold2", 1'b0, 3, 7, 6, 4);

    // Asynchronous reset mid-cycle with a result just captured
    drive(1, 2'b10, 200, 100, 50, 60, 3, 4, 255, 2);
    @(posedge clk); #2;
    chk("pre_reset_r0", r0, 16'd20000);
    rst_n = 1'b0;
    #1;
    expect4("async_reset", 1'b0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); expect4("post_reset", 1'b0, 0, 0, 0, 0);
    @(negedge clk); expect4("post_reset2", 1'b0, 0, 0, 0, 0);

    // Randomized traffic, compared every cycle by the compare process
    for (int n = 0; n < 400; n++) begin
      logic [7:0] va [8];
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 5))
          0:       va[k] = 8'd0;
          1:       va[k] = 8'd255;
          default: va[k] = 8'($urandom_range(0, 255));
        endcase
      end
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            va[0], va[1], va[2], va[3], va[4], va[5], va[6], va[7]);
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
